// File: rtl/fir_frame_sequencer_if.sv
// Streaming handshake bundle for fir_frame_sequencer.
//   in_valid/in_data/in_ready       : sample stream into the frame buffer
//   out_valid/out_data/out_last/out_ready : filtered frame stream out
// Modports:
//   master : upstream source / downstream sink side (testbench, neighbours)
//   slave  : the sequencer side
interface fir_frame_sequencer_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Frame controller for the block FIR low-pass filter. Collects FRAME_LEN
// samples into a frame buffer driven to the filter, pulses the filter clear,
// holds start until the filter reports ready (or TIMEOUT expires), captures
// the filtered frame and streams it out with valid/ready flow control.
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   io           handshake bundle (slave): sample input and frame output
//   flt_in       frame buffer presented to the filter
//   flt_clr      one-cycle filter reset pulse
//   flt_start    filter start flag
//   flt_rdy      filter ready flag (sticky until filter cleared)
//   flt_out      filtered frame from the filter
//   busy         high in CLR/RUN/DRAIN
//   err_timeout  sticky: a frame was aborted waiting for flt_rdy
//   frame_cnt    completed frames, wraps
module fir_frame_sequencer #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned DW        = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  fir_frame_sequencer_if.slave          io,
  output logic [FRAME_LEN-1:0][DW-1:0]  flt_in,
  output logic                          flt_clr,
  output logic                          flt_start,
  input  logic                          flt_rdy,
  input  logic [FRAME_LEN-1:0][DW-1:0]  flt_out,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [7:0]                    frame_cnt
);

  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FILL, CLR, RUN, DRAIN} state_t;

  state_t                       state;
  logic [IW-1:0]                wr_idx;
  logic [IW-1:0]                rd_idx;
  logic [IW-1:0]                rd_next;
  logic [TW-1:0]                timer;
  logic [FRAME_LEN-1:0][DW-1:0] obuf;

  assign rd_next = rd_idx + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_idx       <= '0;
      rd_idx       <= '0;
      timer        <= '0;
      flt_in       <= '0;
      obuf         <= '0;
      flt_clr      <= 1'b0;
      flt_start    <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      frame_cnt    <= '0;
      io.in_ready  <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= FILL;
          io.in_ready <= 1'b1;
        end

        FILL: begin
          if (io.in_valid && io.in_ready) begin
            flt_in[wr_idx] <= io.in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx      <= '0;
              io.in_ready <= 1'b0;
              flt_clr     <= 1'b1;
              busy        <= 1'b1;
              state       <= CLR;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end

        CLR: begin
          flt_clr   <= 1'b0;
          flt_start <= 1'b1;
          timer     <= '0;
          state     <= RUN;
        end

        RUN: begin
          timer <= timer + TW'(1);
          // timer==0 marks the first RUN cycle, where flt_rdy may still be
          // the stale flag from the previous frame. Ready beats timeout.
          if (flt_rdy && (timer != '0)) begin
            obuf         <= flt_out;
            flt_start    <= 1'b0;
            io.out_valid <= 1'b1;
            io.out_data  <= flt_out[0];
            io.out_last  <= (LAST_IDX == '0);
            state        <= DRAIN;
          end else if (timer == LAST_TICK) begin
            err_timeout <= 1'b1;
            flt_start   <= 1'b0;
            busy        <= 1'b0;
            io.in_ready <= 1'b1;
            state       <= FILL;
          end
        end

        DRAIN: begin
          // out_data/out_last are registered and only advance on a
          // handshake, so they stay stable while stalled.
          if (io.out_ready) begin
            if (io.out_last) begin
              rd_idx       <= '0;
              frame_cnt    <= frame_cnt + 8'd1;
              busy         <= 1'b0;
              io.out_valid <= 1'b0;
              io.out_last  <= 1'b0;
              io.out_data  <= '0;
              io.in_ready  <= 1'b1;
              state        <= FILL;
            end else begin
              rd_idx      <= rd_next;
              io.out_data <= obuf[rd_next];
              io.out_last <= (rd_next == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
